// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment display blocks: the segment word
// type, bit positions of each segment within that word, and the active-low
// glyph patterns for hex digits 0-F plus a blank pattern.
// Bit order of a segment word is g..a (bit 6 = g, bit 0 = a); a 0 lights
// the segment (common-anode display).

package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam seg7_t GLYPH_0     = 7'h40;
    localparam seg7_t GLYPH_1     = 7'h79;
    localparam seg7_t GLYPH_2     = 7'h24;
    localparam seg7_t GLYPH_3     = 7'h30;
    localparam seg7_t GLYPH_4     = 7'h19;
    localparam seg7_t GLYPH_5     = 7'h12;
    localparam seg7_t GLYPH_6     = 7'h02;
    localparam seg7_t GLYPH_7     = 7'h78;
    localparam seg7_t GLYPH_8     = 7'h00;
    localparam seg7_t GLYPH_9     = 7'h10;
    localparam seg7_t GLYPH_A     = 7'h08;
    localparam seg7_t GLYPH_B     = 7'h03;
    localparam seg7_t GLYPH_C     = 7'h46;
    localparam seg7_t GLYPH_D     = 7'h21;
    localparam seg7_t GLYPH_E     = 7'h06;
    localparam seg7_t GLYPH_F     = 7'h0E;
    localparam seg7_t GLYPH_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Purely combinational 4-bit code to active-low 7-segment decoder, reusable
// per digit on multi-digit displays.
// Build option: SEG7_HEX_EN defined -> codes 10-15 show hex glyphs A-F;
// undefined -> codes 10-15 show blank.
// Ports:
//   code  in  4  value to display
//   seg   out 7  active-low segment drives, bit0=a .. bit6=g

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    seg7_t pattern;

    always_comb begin
        pattern = GLYPH_BLANK;
        case (code)
            4'd0:  pattern = GLYPH_0;
            4'd1:  pattern = GLYPH_1;
            4'd2:  pattern = GLYPH_2;
            4'd3:  pattern = GLYPH_3;
            4'd4:  pattern = GLYPH_4;
            4'd5:  pattern = GLYPH_5;
            4'd6:  pattern = GLYPH_6;
            4'd7:  pattern = GLYPH_7;
            4'd8:  pattern = GLYPH_8;
            4'd9:  pattern = GLYPH_9;
`ifdef SEG7_HEX_EN
            4'd10: pattern = GLYPH_A;
            4'd11: pattern = GLYPH_B;
            4'd12: pattern = GLYPH_C;
            4'd13: pattern = GLYPH_D;
            4'd14: pattern = GLYPH_E;
            4'd15: pattern = GLYPH_F;
`endif
            default: pattern = GLYPH_BLANK;
        endcase
    end

    assign seg = pattern;

endmodule

// File: rtl/seg7_hex_counter.sv
// seg7_hex_counter
// Free-running single-digit counter for a common-anode 7-segment display.
// A 32-bit prescaler counts enabled clocks 0..TICK_MAX; on the terminal
// count the digit advances and tick pulses for the cycle the new digit is
// first visible. Also drives the RGB status LED (green once out of reset).
// Build option: SEG7_HEX_EN defined -> digit counts 0-F; undefined -> 0-9.
// Parameters:
//   TICK_MAX  terminal prescaler value, digit period = TICK_MAX+1 clocks (>=1)
// Ports:
//   clk                  system clock
//   rst                  synchronous active-high reset
//   en                   count enable; low freezes prescaler and digit
//   seg_n                active-low segment drives, bit0=a .. bit6=g
//   digit                current digit value
//   tick                 one-cycle pulse marking a digit update
//   led_r, led_g, led_b  active-low status LED

module seg7_hex_counter
    import seg7_pkg::*;
#(
    parameter logic [31:0] TICK_MAX = 32'h0040_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [6:0] seg_n,
    output logic [3:0] digit,
    output logic       tick,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);

    logic [31:0] presc;
    logic [3:0]  digit_q;
    logic [3:0]  digit_next;
    logic        tick_q;
    logic        ready_q;

`ifdef SEG7_HEX_EN
    assign digit_next = digit_q + 4'd1;
`else
    assign digit_next = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
`endif

    // Digit and tick update on the same edge, so tick marks exactly the
    // first cycle the new digit is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= 32'd0;
            digit_q <= 4'd0;
            tick_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            tick_q  <= 1'b0;
            if (en) begin
                if (presc == TICK_MAX) begin
                    presc   <= 32'd0;
                    digit_q <= digit_next;
                    tick_q  <= 1'b1;
                end else begin
                    presc <= presc + 32'd1;
                end
            end
        end
    end

    seg7_decode u_decode (
        .code (digit_q),
        .seg  (seg_n)
    );

    assign digit = digit_q;
    assign tick  = tick_q;

    // Only green is ever lit; red and blue stay off.
    assign led_r = 1'b1;
    assign led_g = ~ready_q;
    assign led_b = 1'b1;

endmodule

// File: tb/tb_seg7_hex_counter.sv
module tb_seg7_hex_counter;

    localparam logic [31:0] TM = 32'd3;
    localparam int P = 4;
`ifdef SEG7_HEX_EN
    localparam int MOD = 16;
`else
    localparam int MOD = 10;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] seg_n;
    logic [3:0] digit;
    logic       tick;
    logic       led_r, led_g, led_b;

    logic [3:0] dec_code;
    logic [6:0] dec_seg;

    seg7_hex_counter #(.TICK_MAX(TM)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .seg_n (seg_n),
        .digit (digit),
        .tick  (tick),
        .led_r (led_r),
        .led_g (led_g),
        .led_b (led_b)
    );

    seg7_decode u_dec (
        .code (dec_code),
        .seg  (dec_seg)
    );

    typedef struct {
        logic [3:0] code;
        logic [6:0] exp;
    } dec_vec_t;

    dec_vec_t   dec_tbl[16];
    logic [6:0] seg_ref[16];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: number of enabled edges since the last reset.
    int   e_cnt = 0;
    logic tick_m = 1'b0;
    logic ready_m = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int d;
        @(posedge clk);
        if (rst) begin
            e_cnt   = 0;
            tick_m  = 1'b0;
            ready_m = 1'b0;
        end else begin
            ready_m = 1'b1;
            if (en) begin
                e_cnt++;
                tick_m = ((e_cnt % P) == 0);
            end else begin
                tick_m = 1'b0;
            end
        end
        #1;
        d = (e_cnt / P) % MOD;
        chk("digit", int'(digit), d);
        chk("tick", int'(tick), int'(tick_m));
        chk("seg_n", int'(seg_n), int'(seg_ref[d]));
        chk("led", int'({led_r, led_g, led_b}), ready_m ? 5 : 7);
    endtask

    initial begin
        int   last;
        int   cnt;
        logic got;

        dec_tbl[0]  = '{4'd0,  7'h40};
        dec_tbl[1]  = '{4'd1,  7'h79};
        dec_tbl[2]  = '{4'd2,  7'h24};
        dec_tbl[3]  = '{4'd3,  7'h30};
        dec_tbl[4]  = '{4'd4,  7'h19};
        dec_tbl[5]  = '{4'd5,  7'h12};
        dec_tbl[6]  = '{4'd6,  7'h02};
        dec_tbl[7]  = '{4'd7,  7'h78};
        dec_tbl[8]  = '{4'd8,  7'h00};
        dec_tbl[9]  = '{4'd9,  7'h10};
`ifdef SEG7_HEX_EN
        dec_tbl[10] = '{4'd10, 7'h08};
        dec_tbl[11] = '{4'd11, 7'h03};
        dec_tbl[12] = '{4'd12, 7'h46};
        dec_tbl[13] = '{4'd13, 7'h21};
        dec_tbl[14] = '{4'd14, 7'h06};
        dec_tbl[15] = '{4'd15, 7'h0E};
`else
        dec_tbl[10] = '{4'd10, 7'h7F};
        dec_tbl[11] = '{4'd11, 7'h7F};
        dec_tbl[12] = '{4'd12, 7'h7F};
        dec_tbl[13] = '{4'd13, 7'h7F};
        dec_tbl[14] = '{4'd14, 7'h7F};
        dec_tbl[15] = '{4'd15, 7'h7F};
`endif
        for (int i = 0; i < 16; i++) seg_ref[i] = dec_tbl[i].exp;

        rst = 1'b1;
        en  = 1'b1;
        dec_code = 4'd0;

        // Decoder, all 16 codes.
        for (int i = 0; i < 16; i++) begin
            dec_code = dec_tbl[i].code;
            #1;
            chk("decode", int'(dec_seg), int'(dec_tbl[i].exp));
        end

        // Reset held for 3 cycles, then released.
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;

        // Run through more than a full wrap; ticks every P cycles.
        last = -1;
        for (int i = 0; i < 70; i++) begin
            step();
            if (tick) begin
                if (last >= 0) chk("tick_period", i - last, P);
                else           chk("first_tick", i + 1, P);
                last = i;
            end
        end

        // Pause enable for 10 cycles mid-period: next tick 10 cycles late.
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            got = tick;
        end
        chk("sync_tick", int'(got), 1);
        cnt = 0;
        step(); cnt++;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); cnt++; end
        en = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step(); cnt++;
            got = tick;
        end
        chk("pause_gap", got ? cnt : -1, P + 10);

        // Reset on the terminal-count cycle.
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            got = tick;
        end
        chk("sync_tick2", int'(got), 1);
        for (int i = 0; i < P - 1; i++) step();
        rst = 1'b1;
        step();
        chk("rst_tc_digit", int'(digit), 0);
        chk("rst_tc_tick", int'(tick), 0);
        rst = 1'b0;
        cnt = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step(); cnt++;
            got = tick;
        end
        chk("rst_gap", got ? cnt : -1, P);

        // Randomized enable / occasional reset.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
